fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Decoupling FIFO between instruction fetch and the decode/execute stage of the pipelined DLX core.
- Fetch pushes {instruction word, PC+4} pairs; decode pops them in order through a valid/ready handshake.
- A branch/jump redirect flushes all queued entries in one cycle so wrong-path instructions never reach decode.
- Empty-queue output is a zero bubble (all-zero instruction word, treated as NOP downstream).

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- AW, 2, pointer width; must equal log2(DEPTH).
- IW, 32, instruction and PC width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  reset, asynchronous, active-high
- in_valid  input  1  fetch presents an entry
- in_ready  output  1  queue accepts an entry this cycle
- in_instr  input  IW  fetched instruction word
- in_pc4  input  IW  PC+4 of that instruction
- out_valid  output  1  head entry available to decode
- out_ready  input  1  decode consumes head this cycle
- out_instr  output  IW  head instruction word; 0 when out_valid=0
- out_pc4  output  IW  head PC+4; 0 when out_valid=0
- flush  input  1  redirect: discard all entries
- count  output  AW+1  current occupancy, 0..DEPTH

Behaviour:
- State: storage array mem[DEPTH], wr_ptr[AW], rd_ptr[AW], cnt[AW+1], all registered.
- Reset (async, immediate): wr_ptr=0, rd_ptr=0, cnt=0.
  - Outputs during and after reset: out_valid=0, out_instr=0, out_pc4=0, count=0, in_ready=1 (0 while flush=1).
  - Storage contents are not reset; they are never visible because outputs are gated by out_valid.
- in_ready = ~flush & (cnt != DEPTH). It does not depend on out_ready, so there is no combinational path from decode to fetch.
- push = in_valid & in_ready. When push=1:
  - mem[wr_ptr] <= {in_instr, in_pc4};
  - wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- out_valid = (cnt != 0).
- out_instr/out_pc4 = mem[rd_ptr] when out_valid=1, else 0. This is a combinational read of registered storage.
- pop = out_valid & out_ready & ~flush. When pop=1: rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- cnt update:
  - push&pop: unchanged
  - push only: +1
  - pop only: -1
  - otherwise: unchanged
- Latency: an entry pushed in cycle N is visible at out_* in cycle N+1. There is no same-cycle bypass while empty.
- Throughput: one push and one pop per cycle sustained when 0 < cnt < DEPTH.
- Full (cnt=DEPTH): in_ready=0 even if out_ready=1 the same cycle. The pop still occurs and in_ready returns to 1 the next cycle.
- Empty (cnt=0): out_ready is ignored; no pointer movement; out_* = 0.
- Flush (synchronous, highest priority): on the clock edge wr_ptr=0, rd_ptr=0, cnt=0.
  - No push and no pop occur in the flush cycle.
  - out_valid may be 1 during the flush cycle, but decode must not treat it as consumed.
  - Next cycle: out_valid=0 and in_ready=1.
- Flush while full or empty behaves identically: the queue ends empty.
- Reset asserted mid-stream: all queued entries are lost immediately. After release, the first push lands in mem[0].
- Pointer wrap: after DEPTH pushes/pops, the pointers return to 0. Ordering must be preserved across the wrap.
- Invariant: count equals the number of accepted pushes minus pops since the last reset/flush, and never exceeds DEPTH.

Test Plan:
- Reset then idle -> out_valid=0, out_instr=0x00000000, in_ready=1, count=0.
- Push instr 0x20010005 / pc4 0x00000004 with out_ready=0:
  - next cycle out_valid=1, out_instr=0x20010005, out_pc4=0x00000004, count=1.
- Push 4 entries 0xA0..0xA3 with out_ready=0:
  - count=4, in_ready=0; a fifth push of 0xA4 is not accepted.
  - Then out_ready=1 for 4 cycles -> pops 0xA0,0xA1,0xA2,0xA3 in order, count=0.
- Continuous push+pop of 10 entries 0xB0..0xB9 with out_ready=1:
  - each appears exactly once, in order, one cycle after its push;
  - count stays at 1 in steady state; pointers wrap twice.
- Queue holding 3 entries, assert flush with in_valid=1 (0xC0) and out_ready=1 for one cycle:
  - next cycle count=0, out_valid=0; 0xC0 is not stored.
  - A subsequent push of 0xC1 appears at the head.
- Assert reset asynchronously mid-cycle with 2 entries queued:
  - out_valid=0 and count=0 immediately, without waiting for a clock edge;
  - after release, a push of 0xD0 is the next out_instr.

Source files
------------

// File: rtl/fetch_queue.sv
`default_nettype none
//==============================================================================
// Module   : fetch_queue
// Purpose  : In-order decoupling FIFO between instruction fetch and decode of
//            the pipelined DLX core. Each entry is an {instruction, PC+4} pair.
//            A redirect flush empties the queue in one cycle. When empty, the
//            outputs present an all-zero bubble.
// Ports    : clk, reset            - clock, async active-high reset
//            in_valid/in_ready     - fetch-side handshake
//            in_instr/in_pc4       - entry being pushed
//            out_valid/out_ready   - decode-side handshake
//            out_instr/out_pc4     - head entry (zero when out_valid=0)
//            flush                 - discard all entries at the next edge
//            count                 - current occupancy, 0..DEPTH
// Revision : 1.0 - initial release
//==============================================================================
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int IW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_instr,
  input  logic [IW-1:0] in_pc4,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_instr,
  output logic [IW-1:0] out_pc4,
  input  logic          flush,
  output logic [AW:0]   count
);

  localparam logic [AW:0]   c_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] c_PTR_ONE = AW'(1);

  // Storage is deliberately not reset: stale contents are masked by out_valid.
  logic [2*IW-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_cnt;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [2*IW-1:0] w_head;

  assign w_full  = (r_cnt == c_DEPTH);
  assign w_empty = (r_cnt == '0);

  // in_ready never looks at out_ready, so a full queue cannot accept even if
  // the head is leaving this cycle; this keeps decode->fetch free of comb paths.
  assign in_ready  = ~flush & ~w_full;
  assign out_valid = ~w_empty;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready & ~flush;

  assign w_head    = r_mem[r_rd_ptr];
  assign out_instr = out_valid ? w_head[2*IW-1:IW] : '0;
  assign out_pc4   = out_valid ? w_head[IW-1:0]    : '0;
  assign count     = r_cnt;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_instr, in_pc4};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + c_CNT_ONE;
        2'b01:   r_cnt <= r_cnt - c_CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
//==============================================================================
// Module   : tb_fetch_queue
// Purpose  : Directed, table-driven self-checking bench for fetch_queue, plus
//            hand-written sequences for reset-state and async mid-stream reset.
// Revision : 1.0 - initial release
//==============================================================================
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int IW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_instr;
  logic [IW-1:0] in_pc4;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  logic [IW-1:0] out_pc4;
  logic          flush;
  logic [AW:0]   count;

  fetch_queue #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc4    (in_pc4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc4   (out_pc4),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

  // One record per cycle: inputs driven after the falling edge, expected
  // outputs observed 1 ns later, i.e. before the next rising edge.
  typedef struct {
    logic          iv;
    logic [IW-1:0] instr;
    logic [IW-1:0] pc4;
    logic          ordy;
    logic          fl;
    logic          eov;
    logic [IW-1:0] einstr;
    logic [IW-1:0] epc;
    logic [AW:0]   ecnt;
    logic          eir;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [IW-1:0] pcof(input logic [IW-1:0] x);
    return x + 32'h1000_0000;
  endfunction

  task automatic addv(input logic iv, input logic [IW-1:0] instr, input logic ordy,
                      input logic fl, input logic eov, input logic [IW-1:0] einstr,
                      input logic [AW:0] ecnt, input logic eir);
    vec_t v;
    v.iv = iv; v.instr = instr; v.pc4 = pcof(instr); v.ordy = ordy; v.fl = fl;
    v.eov = eov; v.einstr = einstr; v.epc = eov ? pcof(einstr) : '0;
    v.ecnt = ecnt; v.eir = eir;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [IW-1:0] act,
                     input logic [IW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic eov,
                         input logic [IW-1:0] ei, input logic [IW-1:0] ep,
                         input logic [AW:0] ec, input logic eir);
    chk({tag, ".out_valid"}, idx, IW'(out_valid), IW'(eov));
    chk({tag, ".out_instr"}, idx, out_instr, ei);
    chk({tag, ".out_pc4"},   idx, out_pc4, ep);
    chk({tag, ".count"},     idx, IW'(count), IW'(ec));
    chk({tag, ".in_ready"},  idx, IW'(in_ready), IW'(eir));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc4 = '0;
    out_ready = 1'b0; flush = 1'b0;
    #1;
    chk_all("reset", 0, 1'b0, '0, '0, '0, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Single push: no bypass, visible one cycle later, then popped.
    vecs.push_back('{iv:1'b0, instr:'0, pc4:'0, ordy:1'b0, fl:1'b0,
                     eov:1'b0, einstr:'0, epc:'0, ecnt:3'd0, eir:1'b1});
    vecs.push_back('{iv:1'b1, instr:32'h2001_0005, pc4:32'h0000_0004, ordy:1'b0, fl:1'b0,
                     eov:1'b0, einstr:'0, epc:'0, ecnt:3'd0, eir:1'b1});
    vecs.push_back('{iv:1'b0, instr:'0, pc4:'0, ordy:1'b0, fl:1'b0,
                     eov:1'b1, einstr:32'h2001_0005, epc:32'h0000_0004, ecnt:3'd1, eir:1'b1});
    vecs.push_back('{iv:1'b0, instr:'0, pc4:'0, ordy:1'b1, fl:1'b0,
                     eov:1'b1, einstr:32'h2001_0005, epc:32'h0000_0004, ecnt:3'd1, eir:1'b1});
    // Empty: out_ready ignored.
    addv(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0, 1'b1);
    // Fill to DEPTH, reject fifth push while popping, drain in order.
    addv(1'b1, 32'hA0, 1'b0, 1'b0, 1'b0, 32'h0,  3'd0, 1'b1);
    addv(1'b1, 32'hA1, 1'b0, 1'b0, 1'b1, 32'hA0, 3'd1, 1'b1);
    addv(1'b1, 32'hA2, 1'b0, 1'b0, 1'b1, 32'hA0, 3'd2, 1'b1);
    addv(1'b1, 32'hA3, 1'b0, 1'b0, 1'b1, 32'hA0, 3'd3, 1'b1);
    addv(1'b1, 32'hA4, 1'b1, 1'b0, 1'b1, 32'hA0, 3'd4, 1'b0);
    addv(1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'hA1, 3'd3, 1'b1);
    addv(1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'hA2, 3'd2, 1'b1);
    addv(1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'hA3, 3'd1, 1'b1);
    addv(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  3'd0, 1'b1);
    // Streaming B0..B9: each head is the previous push, count held at 1.
    addv(1'b1, 32'hB0, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0, 1'b1);
    for (int k = 1; k < 10; k++)
      addv(1'b1, 32'hB0 + k, 1'b1, 1'b0, 1'b1, 32'hB0 + k - 1, 3'd1, 1'b1);
    addv(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hB9, 3'd1, 1'b1);
    addv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,  3'd0, 1'b1);
    // Three entries, then flush with push+pop requested.
    addv(1'b1, 32'hE0, 1'b0, 1'b0, 1'b0, 32'h0,  3'd0, 1'b1);
    addv(1'b1, 32'hE1, 1'b0, 1'b0, 1'b1, 32'hE0, 3'd1, 1'b1);
    addv(1'b1, 32'hE2, 1'b0, 1'b0, 1'b1, 32'hE0, 3'd2, 1'b1);
    addv(1'b1, 32'hC0, 1'b1, 1'b1, 1'b1, 32'hE0, 3'd3, 1'b0);
    addv(1'b1, 32'hC1, 1'b0, 1'b0, 1'b0, 32'h0,  3'd0, 1'b1);
    addv(1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'hC1, 3'd1, 1'b1);
    addv(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  3'd0, 1'b1);
    // Flush while empty with a push attempt: nothing stored.
    addv(1'b1, 32'hC2, 1'b0, 1'b1, 1'b0, 32'h0,  3'd0, 1'b0);
    addv(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  3'd0, 1'b1);

    foreach (vecs[i]) begin
      @(negedge clk);
      in_valid = vecs[i].iv; in_instr = vecs[i].instr; in_pc4 = vecs[i].pc4;
      out_ready = vecs[i].ordy; flush = vecs[i].fl;
      #1;
      chk_all("vec", i, vecs[i].eov, vecs[i].einstr, vecs[i].epc, vecs[i].ecnt, vecs[i].eir);
    end

    // Asynchronous reset with two entries queued.
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'hF0; in_pc4 = pcof(32'hF0); out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    in_instr = 32'hF1; in_pc4 = pcof(32'hF1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk_all("pre_reset", 0, 1'b1, 32'hF0, pcof(32'hF0), 3'd2, 1'b1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk_all("async_reset", 0, 1'b0, '0, '0, 3'd0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b1; in_instr = 32'hD0; in_pc4 = pcof(32'hD0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk_all("after_reset", 0, 1'b1, 32'hD0, pcof(32'hD0), 3'd1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
